// File: rtl/lfsr_8bit_checker_pkg.sv
// rtl/lfsr_8bit_checker_pkg.sv - shared LFSR8 seed, feedback taps and checker state encoding
package lfsr_8bit_checker_pkg;

    localparam logic [7:0] LFSR8_SEED = 8'b01000010;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // Generator and checker share this tap set so the polynomial lives in one place.
    function automatic logic lfsr8_fb(input logic [7:0] s);
        return s[7] ^ s[5] ^ s[4] ^ s[3];
    endfunction

endpackage

// File: rtl/lfsr_8bit_checker_sat_counter.sv
// rtl/lfsr_8bit_checker_sat_counter.sv - saturating up-counter, clear wins but a same-cycle increment still counts
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/lfsr_8bit_checker.sv
// rtl/lfsr_8bit_checker.sv - self-synchronising receive checker for the 8-bit LFSR bit stream
module lfsr_8bit_checker
    import lfsr_8bit_checker_pkg::*;
#(
    parameter int LOCK_THRESH   = 16,
    parameter int UNLOCK_THRESH = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
    localparam int MISS_W  = $clog2(UNLOCK_THRESH + 1);

    chk_state_t         state_q, state_d;
    logic [7:0]         r_q, r_d;
    logic [3:0]         fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               pulse_d;
    logic               err_inc;
    logic               pred;

    assign pred   = lfsr8_fb(r_q);
    assign locked = (state_q == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEARCH;
            r_q       <= 8'h00;
            fill_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            err_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            err_pulse <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        pulse_d = 1'b0;
        err_inc = 1'b0;
        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    r_d = {in_bit, r_q[7:1]};
                    if (fill_q < 4'd8) begin
                        fill_d = fill_q + 4'd1;
                    end else if ((in_bit == pred) && (r_q != 8'h00)) begin
                        // Lock on the threshold match itself; counter is parked at 0 to avoid wrap.
                        if (match_q == MATCH_W'(LOCK_THRESH - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    r_d = {pred, r_q[7:1]};
                    if (in_bit != pred) begin
                        err_inc = 1'b1;
                        pulse_d = 1'b1;
                        if (miss_q == MISS_W'(UNLOCK_THRESH - 1)) begin
                            state_d = SEARCH;
                            fill_d  = '0;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear_cnt),
        .inc  (err_inc),
        .count(err_cnt)
    );

endmodule

// File: tb/tb_lfsr_8bit_checker.sv
// tb/tb_lfsr_8bit_checker.sv - scoreboard bench for lfsr_8bit_checker against a bit-history reference model
module tb_lfsr_8bit_checker;
    import lfsr_8bit_checker_pkg::*;

    localparam int LT   = 16;
    localparam int UT   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic          clear_cnt = 1'b0;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_cnt;

    always #5 clk = ~clk;

    lfsr_8bit_checker #(
        .LOCK_THRESH  (LT),
        .UNLOCK_THRESH(UT),
        .CNT_W        (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .clear_cnt(clear_cnt),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt)
    );

    typedef struct {
        int lck;
        int pulse;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("sb_locked", int'(locked), e.lck);
            check("sb_err_pulse", int'(err_pulse), e.pulse);
            check("sb_err_cnt", int'(err_cnt), e.cnt);
        end
    end

    // Reference: the last 8 received (or flywheeled) bits, oldest first, plus plain integer counters.
    bit m_hist[$];
    int m_locked, m_filled, m_match, m_miss, m_cnt, m_pulse;

    task automatic model_step(input bit r, input bit v, input bit b, input bit c);
        bit pred, zero, err;
        if (r) begin
            m_hist.delete();
            repeat (8) m_hist.push_back(1'b0);
            m_locked = 0; m_filled = 0; m_match = 0; m_miss = 0; m_cnt = 0; m_pulse = 0;
            return;
        end
        err = 1'b0;
        if (v) begin
            pred = m_hist[7] ^ m_hist[5] ^ m_hist[4] ^ m_hist[3];
            zero = 1'b1;
            foreach (m_hist[i]) if (m_hist[i]) zero = 1'b0;
            void'(m_hist.pop_front());
            if (m_locked == 0) begin
                m_hist.push_back(b);
                if (m_filled < 8) m_filled++;
                else if (b == pred && !zero) begin
                    m_match++;
                    if (m_match == LT) begin
                        m_locked = 1; m_miss = 0; m_match = 0;
                    end
                end else m_match = 0;
            end else begin
                m_hist.push_back(pred);
                if (b != pred) begin
                    err = 1'b1;
                    m_miss++;
                    if (m_miss == UT) begin
                        m_locked = 0; m_filled = 0; m_match = 0; m_miss = 0;
                    end
                end else m_miss = 0;
            end
        end
        m_pulse = int'(err);
        if (c) m_cnt = err ? 1 : 0;
        else if (err && m_cnt < CMAX) m_cnt++;
    endtask

    // Generator: seed bits first, then every bit is the XOR of stream bits 1,3,4,5 back.
    bit g_bits[$];

    function automatic bit gen_next();
        logic [7:0] seed;
        int n;
        bit b;
        seed = LFSR8_SEED;
        n = g_bits.size();
        if (n < 8) b = seed[n];
        else b = g_bits[n-1] ^ g_bits[n-3] ^ g_bits[n-4] ^ g_bits[n-5];
        g_bits.push_back(b);
        return b;
    endfunction

    task automatic drive(input bit r, input bit v, input bit b, input bit c);
        exp_t e;
        rst = r; in_valid = v; in_bit = b; clear_cnt = c;
        model_step(r, v, b, c);
        e.lck = m_locked; e.pulse = m_pulse; e.cnt = m_cnt;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic feed(input bit flip);
        bit b;
        b = gen_next();
        drive(1'b0, 1'b1, b ^ flip, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'($urandom), 1'b0);
    endtask

    task automatic bits_to_lock(input bit gaps, output int n);
        n = 0;
        for (int i = 0; i < 400 && !locked; i++) begin
            if (gaps && $urandom_range(1) == 0) idle();
            else begin
                feed(1'b0);
                n++;
            end
        end
    endtask

    initial begin
        int n;
        bit saw_lock;

        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_locked", int'(locked), 0);
        check("reset_err_cnt", int'(err_cnt), 0);

        // Clean stream from seed: 23 bits not yet locked, 24th bit locks.
        for (int i = 0; i < 23; i++) feed(1'b0);
        check("pre_lock_23", int'(locked), 0);
        feed(1'b0);
        check("lock_at_24", int'(locked), 1);
        check("clean_err_cnt", int'(err_cnt), 0);

        // Single inverted bit while locked.
        repeat (10) feed(1'b0);
        feed(1'b1);
        check("single_pulse", int'(err_pulse), 1);
        feed(1'b0);
        check("single_pulse_gone", int'(err_pulse), 0);
        repeat (10) feed(1'b0);
        check("single_err_cnt", int'(err_cnt), 1);
        check("single_still_locked", int'(locked), 1);

        // Four consecutive errors unlock; then relock after 24 valid bits.
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("clear_idle", int'(err_cnt), 0);
        for (int i = 0; i < 3; i++) feed(1'b1);
        check("burst3_locked", int'(locked), 1);
        feed(1'b1);
        check("burst4_unlocked", int'(locked), 0);
        check("burst4_err_cnt", int'(err_cnt), 4);
        check("burst4_pulse", int'(err_pulse), 1);
        bits_to_lock(1'b0, n);
        check("relock_bits", n, 24);

        // Degenerate streams never lock.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        saw_lock = 1'b0;
        for (int i = 0; i < 128; i++) begin
            drive(1'b0, 1'b1, (i >= 64), 1'b0);
            if (locked) saw_lock = 1'b1;
        end
        check("const_never_lock", int'(saw_lock), 0);
        check("const_err_cnt", int'(err_cnt), 0);

        // Gapped clean stream from seed, then saturate the error counter.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        g_bits.delete();
        bits_to_lock(1'b1, n);
        check("gap_lock_bits", n, 24);
        for (int k = 0; k < 20; k++) begin
            feed(1'b1);
            for (int j = 0; j < 5; j++) begin
                if ($urandom_range(1) == 0) idle();
                feed(1'b0);
            end
        end
        check("sat_err_cnt", int'(err_cnt), CMAX);
        check("sat_still_locked", int'(locked), 1);
        drive(1'b0, 1'b1, gen_next() ^ 1'b1, 1'b1);
        check("clear_on_err", int'(err_cnt), 1);

        // Mid-stream reset right after an error discards everything.
        feed(1'b0);
        feed(1'b1);
        drive(1'b1, 1'b1, gen_next(), 1'b0);
        check("midrst_locked", int'(locked), 0);
        check("midrst_pulse", int'(err_pulse), 0);
        check("midrst_err_cnt", int'(err_cnt), 0);
        bits_to_lock(1'b0, n);
        check("midrst_relock_bits", n, 24);

        // Random traffic against the model only.
        for (int i = 0; i < 3000; i++) begin
            bit v, b, c, r;
            v = ($urandom_range(3) != 0);
            c = ($urandom_range(31) == 0);
            r = ($urandom_range(999) == 0);
            b = 1'($urandom);
            if (v) b = gen_next() ^ ($urandom_range(15) == 0);
            drive(r, v, b, c);
        end

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
